// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the threshold FIFO family.
// No logic, so no latency.
// No flow control here.
package fifo_pkg;

  localparam int FIFO_LEN_DEFAULT  = 8;
  localparam int BITNUMBER_DEFAULT = 6;

  // Ceiling log2. It is a constant function, so it can be used to size ports and parameters.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_thresh_if.sv
// Bundles the producer/consumer handshake, the thresholds and the FIFO status.
// The bundle is pure wiring, so it adds no latency.
// Backpressure travels in pause, can_pop, and the full/empty flags driven by the slave.
interface fifo_thresh_if
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = BITNUMBER_DEFAULT,
  parameter int LENGTH    = FIFO_LEN_DEFAULT
);
  localparam int CNTW = clog2(LENGTH + 1);

  logic                 Fifo_wr;
  logic [BITNUMBER-1:0] Fifo_Data_in;
  logic                 Fifo_rd;
  logic [CNTW-1:0]      Umbral_af;
  logic [CNTW-1:0]      Umbral_ae;
  logic [BITNUMBER-1:0] Fifo_Data_out;
  logic                 valid_read;
  logic                 Fifo_full;
  logic                 Fifo_empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [CNTW-1:0]      occupancy;
  logic                 Fifo_rd_error;
  logic                 Fifo_wr_error;
  logic                 Fifo_error;
  logic                 pause;
  logic                 can_pop;

  modport master (
    output Fifo_wr, Fifo_Data_in, Fifo_rd, Umbral_af, Umbral_ae,
    input  Fifo_Data_out, valid_read, Fifo_full, Fifo_empty, almost_full,
           almost_empty, occupancy, Fifo_rd_error, Fifo_wr_error, Fifo_error,
           pause, can_pop
  );

  modport slave (
    input  Fifo_wr, Fifo_Data_in, Fifo_rd, Umbral_af, Umbral_ae,
    output Fifo_Data_out, valid_read, Fifo_full, Fifo_empty, almost_full,
           almost_empty, occupancy, Fifo_rd_error, Fifo_wr_error, Fifo_error,
           pause, can_pop
  );
endinterface

// File: rtl/fifo_mem.sv
// Dual-port register array: write and read are both synchronous.
// Read data appears 1 cycle after rd_en. Write data is visible to reads from the next cycle.
// There is no flow control; callers gate wr_en and rd_en.
module fifo_mem #(
  parameter int BITNUMBER = 6,
  parameter int LENGTH    = 8,
  parameter int PTRW      = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PTRW-1:0]      wr_ptr,
  input  logic [BITNUMBER-1:0] wr_dat,
  input  logic                 rd_en,
  input  logic [PTRW-1:0]      rd_ptr,
  output logic [BITNUMBER-1:0] rd_dat
);
  logic [BITNUMBER-1:0] mem [LENGTH];

  // Store the pushed word. The storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  // Register the word being popped. At full, a same-cycle write to this slot lands after the old value is read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_dat <= mem[rd_ptr];
  end
endmodule

// File: rtl/fifo_thresh.sv
// Power-of-two FIFO with runtime almost-full/almost-empty thresholds, occupancy and error flags.
// Read latency is 1 cycle. A push becomes poppable 1 cycle later, with no bypass.
// Backpressure: pause = almost_full|full. A push at full is accepted only with a same-cycle pop.
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = BITNUMBER_DEFAULT,
  parameter int LENGTH    = FIFO_LEN_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  fifo_thresh_if.slave  bus
);
  localparam int PTRW = clog2(LENGTH);
  localparam int CNTW = clog2(LENGTH + 1);
  localparam logic [CNTW-1:0] LEN_C = CNTW'(LENGTH);

  logic [PTRW-1:0]      wr_ptr, rd_ptr;
  logic [CNTW-1:0]      occ, occ_next, af_lvl;
  logic                 pop_ok, push_ok, wr_err_c, rd_err_c;
  logic                 full_q, empty_q, af_q, ae_q, vld_q;
  logic                 wr_err_q, rd_err_q, err_q, have_data;
  logic [BITNUMBER-1:0] mem_rd_dat;

  assign pop_ok   = bus.Fifo_rd & ~empty_q;
  assign push_ok  = bus.Fifo_wr & (~full_q | bus.Fifo_rd);
  assign wr_err_c = bus.Fifo_wr & full_q & ~bus.Fifo_rd;
  assign rd_err_c = bus.Fifo_rd & empty_q;
  assign occ_next = occ + CNTW'(push_ok) - CNTW'(pop_ok);
  // A margin larger than the depth clamps the almost-full level to 0.
  assign af_lvl   = (bus.Umbral_af > LEN_C) ? '0 : LEN_C - bus.Umbral_af;

  fifo_mem #(
    .BITNUMBER (BITNUMBER),
    .LENGTH    (LENGTH),
    .PTRW      (PTRW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push_ok),
    .wr_ptr (wr_ptr),
    .wr_dat (bus.Fifo_Data_in),
    .rd_en  (pop_ok),
    .rd_ptr (rd_ptr),
    .rd_dat (mem_rd_dat)
  );

  // Update pointers, occupancy and every flag from next occupancy, so they agree every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      vld_q     <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      err_q     <= 1'b0;
      have_data <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTRW'(1);
      if (pop_ok)  have_data <= 1'b1;
      occ      <= occ_next;
      full_q   <= (occ_next == LEN_C);
      empty_q  <= (occ_next == '0);
      af_q     <= (occ_next >= af_lvl);
      ae_q     <= (occ_next <= bus.Umbral_ae);
      vld_q    <= pop_ok;
      wr_err_q <= wr_err_c;
      rd_err_q <= rd_err_c;
      err_q    <= err_q | wr_err_c | rd_err_c;
    end
  end

  // The memory read register has no reset. Until the first pop, mask it so Data_out reads 0 out of reset.
  assign bus.Fifo_Data_out = have_data ? mem_rd_dat : '0;
  assign bus.valid_read    = vld_q;
  assign bus.Fifo_full     = full_q;
  assign bus.Fifo_empty    = empty_q;
  assign bus.almost_full   = af_q;
  assign bus.almost_empty  = ae_q;
  assign bus.occupancy     = occ;
  assign bus.Fifo_wr_error = wr_err_q;
  assign bus.Fifo_rd_error = rd_err_q;
  assign bus.Fifo_error    = err_q;
  assign bus.pause         = af_q | full_q;
  assign bus.can_pop       = ~empty_q;
endmodule
